// File: rtl/key_toggle_bank.sv
// key_toggle_bank: N independent front-panel key channels. Each channel
// synchronises its raw key, debounces it with a stability counter, emits a
// one-cycle pulse on an accepted press and on a long hold, and keeps a
// per-key control state that is either toggled by presses or mirrors the
// debounced level (momentary mode).
module key_toggle_bank #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 100000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] keys_in,
  input  logic [N_KEYS-1:0] mode,
  input  logic [N_KEYS-1:0] clear,
  output logic [N_KEYS-1:0] state_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] hold_pulse
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  // A level is accepted on the edge where the counter would reach DEBOUNCE_CYCLES.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [N_KEYS-1:0] pressed_raw;
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] db_level_q, db_level_d;
  logic [N_KEYS-1:0][DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [N_KEYS-1:0][HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_KEYS-1:0] state_q, state_d;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] hold_q, hold_d;

  // Normalise polarity before the synchroniser so reset value 0 means released.
  assign pressed_raw = keys_in ^ {N_KEYS{KEY_ACTIVE_LOW}};

  // Two-flop synchroniser for the asynchronous key inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-key debounce, edge detect, control state and hold timer next-state.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    state_d    = state_q;
    press_d    = '0;
    hold_d     = '0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (sync2_q[k] != db_level_q[k]) begin
        if (db_cnt_q[k] == DB_LAST) begin
          db_level_d[k] = sync2_q[k];
          db_cnt_d[k]   = '0;
        end else begin
          db_cnt_d[k] = db_cnt_q[k] + 1'b1;
        end
      end else begin
        db_cnt_d[k] = '0;
      end

      press_d[k] = db_level_d[k] & ~db_level_q[k];

      // Clear only matters in toggle mode and beats a coincident press.
      if (mode[k]) begin
        state_d[k] = db_level_d[k];
      end else if (clear[k]) begin
        state_d[k] = 1'b0;
      end else if (press_d[k]) begin
        state_d[k] = ~state_q[k];
      end

      // Timer starts at zero on the press edge and saturates at HOLD_CYCLES,
      // so the pulse fires exactly once per press.
      if (!db_level_d[k]) begin
        hold_cnt_d[k] = '0;
      end else if (db_level_q[k] && (hold_cnt_q[k] != HOLD_MAX)) begin
        hold_cnt_d[k] = hold_cnt_q[k] + 1'b1;
        hold_d[k]     = (hold_cnt_q[k] == HOLD_LAST);
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_level_q <= '0;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      state_q    <= '0;
      press_q    <= '0;
      hold_q     <= '0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      hold_q     <= hold_d;
    end
  end

  assign state_out   = state_q;
  assign press_pulse = press_q;
  assign hold_pulse  = hold_q;

endmodule
